// File: rtl/mem_responder.sv
// mem_responder: single-outstanding data-memory responder with an internal
// little-endian dword RAM, LR/SC reservation and AMO read-modify-write.
module mem_responder #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_ext,
  input  logic [4:0]  req_amo,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_LR    = 3'b101;
  localparam logic [2:0] OP_SC    = 3'b110;
  localparam logic [2:0] OP_AMO   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  logic [63:0]   mem [DEPTH];

  state_e        state_q, state_d;
  logic [63:0]   rdata_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic          lane_hi_q;
  logic          is_dw_q;
  logic [4:0]    amo_q;
  logic [63:0]   wdata_q;
  logic [63:0]   new_q;
  logic          resv_valid_q;
  logic [60:0]   resv_addr_q;

  logic          accept;
  logic          misaligned, out_of_range, op_known, atomic, amo_ok, fault;
  logic [AW-1:0] req_idx;
  logic [63:0]   rd_shift, load_data;
  logic          load_signed, resv_hit;
  logic [7:0]    st_mask;
  logic [63:0]   amo_raw, amo_a, amo_b, amo_r, amo_new;
  logic          amo_slt, amo_ult;
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [7:0]    mem_be;
  logic [63:0]   mem_wdata;

  assign accept   = (state_q == S_IDLE) && req_valid;
  assign req_idx  = req_addr[AW+2:3];
  assign resv_hit = resv_valid_q && (resv_addr_q == req_addr[63:3]);

  // Accept-time fault decode and load-data extraction for the incoming request
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
    out_of_range = |req_addr[63:AW+3];
    op_known = (req_op == OP_LOAD) || (req_op == OP_STORE) || (req_op == OP_LR) ||
               (req_op == OP_SC) || (req_op == OP_AMO);
    atomic = (req_op == OP_LR) || (req_op == OP_SC) || (req_op == OP_AMO);
    case (req_amo)
      5'b00000, 5'b00001, 5'b00100, 5'b01000, 5'b01100,
      5'b10000, 5'b10100, 5'b11000, 5'b11100: amo_ok = 1'b1;
      default:                                 amo_ok = 1'b0;
    endcase
    fault = misaligned || out_of_range || !op_known || (atomic && !req_size[1]) ||
            ((req_op == OP_AMO) && !amo_ok);

    rd_shift    = mem[req_idx] >> {req_addr[2:0], 3'b000};
    load_signed = req_ext || (req_op == OP_LR);
    case (req_size)
      2'd0:    load_data = {{56{load_signed & rd_shift[7]}},  rd_shift[7:0]};
      2'd1:    load_data = {{48{load_signed & rd_shift[15]}}, rd_shift[15:0]};
      2'd2:    load_data = {{32{load_signed & rd_shift[31]}}, rd_shift[31:0]};
      default: load_data = rd_shift;
    endcase

    case (req_size)
      2'd0:    st_mask = 8'h01;
      2'd1:    st_mask = 8'h03;
      2'd2:    st_mask = 8'h0F;
      default: st_mask = 8'hFF;
    endcase
  end

  // AMO datapath: old value (sign-extended for word size) and merged new dword
  always_comb begin
    amo_raw = mem[idx_q];
    amo_a   = is_dw_q ? amo_raw :
              (lane_hi_q ? {{32{amo_raw[63]}}, amo_raw[63:32]} : {{32{amo_raw[31]}}, amo_raw[31:0]});
    amo_b   = is_dw_q ? wdata_q : {{32{wdata_q[31]}}, wdata_q[31:0]};
    amo_slt = $signed(amo_a) < $signed(amo_b);
    amo_ult = is_dw_q ? (amo_a < amo_b) : (amo_a[31:0] < amo_b[31:0]);
    case (amo_q)
      5'b00000: amo_r = amo_a + amo_b;
      5'b00001: amo_r = amo_b;
      5'b00100: amo_r = amo_a ^ amo_b;
      5'b01000: amo_r = amo_a | amo_b;
      5'b01100: amo_r = amo_a & amo_b;
      5'b10000: amo_r = amo_slt ? amo_a : amo_b;
      5'b10100: amo_r = amo_slt ? amo_b : amo_a;
      5'b11000: amo_r = amo_ult ? amo_a : amo_b;
      5'b11100: amo_r = amo_ult ? amo_b : amo_a;
      default:  amo_r = amo_a;
    endcase
    if (is_dw_q) begin
      amo_new = amo_r;
    end else if (lane_hi_q) begin
      amo_new = {amo_r[31:0], amo_raw[31:0]};
    end else begin
      amo_new = {amo_raw[63:32], amo_r[31:0]};
    end
  end

  // RAM write port: STORE and successful SC write at accept, AMO writes in WRITE
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = req_idx;
    mem_be    = st_mask << req_addr[2:0];
    mem_wdata = req_wdata << {req_addr[2:0], 3'b000};
    if (state_q == S_WRITE) begin
      mem_we    = 1'b1;
      mem_idx   = idx_q;
      mem_be    = 8'hFF;
      mem_wdata = new_q;
    end else if (accept && !fault) begin
      mem_we = (req_op == OP_STORE) || ((req_op == OP_SC) && resv_hit);
    end
  end

  // RAM storage, deliberately not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_we && mem_be[i]) mem[mem_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ((req_op == OP_AMO) && !fault) ? S_READ : S_RESP;
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // State register, captured request, response data and reservation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      lane_hi_q    <= 1'b0;
      is_dw_q      <= 1'b0;
      amo_q        <= '0;
      wdata_q      <= '0;
      new_q        <= '0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q   <= fault;
        rdata_q <= '0;
        if (!fault) begin
          idx_q     <= req_idx;
          lane_hi_q <= req_addr[2];
          is_dw_q   <= (req_size == 2'd3);
          amo_q     <= req_amo;
          wdata_q   <= req_wdata;
          case (req_op)
            OP_LOAD: rdata_q <= load_data;
            OP_LR: begin
              rdata_q      <= load_data;
              resv_valid_q <= 1'b1;
              resv_addr_q  <= req_addr[63:3];
            end
            OP_STORE, OP_AMO: begin
              if (resv_hit) resv_valid_q <= 1'b0;
            end
            OP_SC: begin
              rdata_q      <= resv_hit ? 64'd0 : 64'd1;
              resv_valid_q <= 1'b0;
            end
            default: ;
          endcase
        end
      end else if (state_q == S_READ) begin
        rdata_q <= amo_a;
        new_q   <= amo_new;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table plus hand-written multi-cycle
// sequences (backpressure, reset during AMO) for mem_responder.
module tb_mem_responder;

  localparam logic [2:0] LOAD  = 3'b001;
  localparam logic [2:0] STORE = 3'b010;
  localparam logic [2:0] LR    = 3'b101;
  localparam logic [2:0] SC    = 3'b110;
  localparam logic [2:0] AMO   = 3'b111;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        ext;
    logic [4:0]  amo;
    logic [63:0] wdata;
    logic [63:0] expData;
    logic        expErr;
    int          expLat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_ext;
  logic [4:0]  req_amo;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int   testsRun = 0;
  int   testsFailed = 0;
  vec_t vecs[$];

  mem_responder #(.DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_size(req_size), .req_ext(req_ext),
    .req_amo(req_amo), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string name, input logic [2:0] op, input logic [63:0] addr,
                        input logic [1:0] size, input logic ext, input logic [4:0] amo,
                        input logic [63:0] wdata, input logic [63:0] expData,
                        input logic expErr, input int expLat);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.size = size; v.ext = ext; v.amo = amo;
    v.wdata = wdata; v.expData = expData; v.expErr = expErr; v.expLat = expLat;
    vecs.push_back(v);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge, idle again.
  task automatic applyStimulus(input vec_t v);
    int lat;
    checkOutput({v.name, " req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_size = v.size;
    req_ext = v.ext; req_amo = v.amo; req_wdata = v.wdata; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({v.name, " latency"}, 64'(lat), 64'(v.expLat));
    checkOutput({v.name, " rdata"}, rsp_rdata, v.expData);
    checkOutput({v.name, " err"}, 64'(rsp_err), 64'(v.expErr));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = LOAD; req_addr = '0; req_size = '0;
    req_ext = 1'b0; req_amo = '0; req_wdata = '0; rsp_ready = 1'b1;

    //      name           op     addr       sz ext amo       wdata                   expData                 err lat
    addVec("st d 0x10",    STORE, 64'h10,    3, 0, 5'b00000, 64'h8000_0000_FFFF_FF80, 64'h0,                   0, 1);
    addVec("ld b sx",      LOAD,  64'h10,    0, 1, 5'b00000, 64'h0, 64'hFFFF_FFFF_FFFF_FF80,                   0, 1);
    addVec("ld b zx",      LOAD,  64'h10,    0, 0, 5'b00000, 64'h0, 64'h80,                                    0, 1);
    addVec("ld w 0x14 sx", LOAD,  64'h14,    2, 1, 5'b00000, 64'h0, 64'hFFFF_FFFF_8000_0000,                   0, 1);
    addVec("ld h 0x12 zx", LOAD,  64'h12,    1, 0, 5'b00000, 64'h0, 64'hFFFF,                                  0, 1);
    addVec("st d 0x40",    STORE, 64'h40,    3, 0, 5'b00000, 64'h1234, 64'h0,                                  0, 1);
    addVec("lr d 0x40",    LR,    64'h40,    3, 0, 5'b00000, 64'h0, 64'h1234,                                  0, 1);
    addVec("sc ok",        SC,    64'h40,    3, 0, 5'b00000, 64'h5, 64'h0,                                     0, 1);
    addVec("ld after sc",  LOAD,  64'h40,    3, 0, 5'b00000, 64'h0, 64'h5,                                     0, 1);
    addVec("sc again",     SC,    64'h40,    3, 0, 5'b00000, 64'h7, 64'h1,                                     0, 1);
    addVec("ld no write",  LOAD,  64'h40,    3, 0, 5'b00000, 64'h0, 64'h5,                                     0, 1);
    addVec("lr 2",         LR,    64'h40,    3, 0, 5'b00000, 64'h0, 64'h5,                                     0, 1);
    addVec("st clr resv",  STORE, 64'h40,    3, 0, 5'b00000, 64'h9, 64'h0,                                     0, 1);
    addVec("sc after st",  SC,    64'h40,    3, 0, 5'b00000, 64'hA, 64'h1,                                     0, 1);
    addVec("ld 0x40",      LOAD,  64'h40,    3, 0, 5'b00000, 64'h0, 64'h9,                                     0, 1);
    addVec("st w 0x80",    STORE, 64'h80,    2, 0, 5'b00000, 64'hFFFF_FFFE, 64'h0,                             0, 1);
    addVec("amo min.w",    AMO,   64'h80,    2, 0, 5'b10000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE,                   0, 3);
    addVec("ld min.w",     LOAD,  64'h80,    2, 0, 5'b00000, 64'h0, 64'hFFFF_FFFE,                             0, 1);
    addVec("amo minu.w",   AMO,   64'h80,    2, 0, 5'b11000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE,                   0, 3);
    addVec("ld minu.w",    LOAD,  64'h80,    2, 0, 5'b00000, 64'h0, 64'h1,                                     0, 1);
    addVec("st w 0x84",    STORE, 64'h84,    2, 0, 5'b00000, 64'h10, 64'h0,                                    0, 1);
    addVec("amo xor.w hi", AMO,   64'h84,    2, 0, 5'b00100, 64'h3, 64'h10,                                    0, 3);
    addVec("ld d 0x80",    LOAD,  64'h80,    3, 0, 5'b00000, 64'h0, 64'h0000_0013_0000_0001,                   0, 1);
    addVec("st d 0x88",    STORE, 64'h88,    3, 0, 5'b00000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0,                   0, 1);
    addVec("amo add.d",    AMO,   64'h88,    3, 0, 5'b00000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF,                   0, 3);
    addVec("ld add.d",     LOAD,  64'h88,    3, 0, 5'b00000, 64'h0, 64'h8000_0000_0000_0000,                   0, 1);
    addVec("flt misalign", LOAD,  64'h3,     1, 0, 5'b00000, 64'h0, 64'h0,                                     1, 1);
    addVec("flt range",    LOAD,  64'h2000,  3, 0, 5'b00000, 64'h0, 64'h0,                                     1, 1);
    addVec("flt lr byte",  LR,    64'h40,    0, 0, 5'b00000, 64'h0, 64'h0,                                     1, 1);
    addVec("flt amo fn",   AMO,   64'h80,    2, 0, 5'b00010, 64'h5, 64'h0,                                     1, 1);
    addVec("flt bad op",   3'b000, 64'h80,   2, 0, 5'b00000, 64'h0, 64'h0,                                     1, 1);
    addVec("ld after flt", LOAD,  64'h80,    3, 0, 5'b00000, 64'h0, 64'h0000_0013_0000_0001,                   0, 1);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset req_ready", 64'(req_ready), 64'd1);
    checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset rdata", rsp_rdata, 64'd0);
    checkOutput("reset err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Backpressure: response held for 5 cycles, next request right after handshake
    req_valid = 1'b1; req_op = LOAD; req_addr = 64'h40; req_size = 2'd3; req_ext = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("bp rdata", rsp_rdata, 64'h9);
      checkOutput("bp req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp done rsp_valid", 64'(rsp_valid), 64'd0);
    applyStimulus('{"bp next ld", LOAD, 64'h10, 2'd3, 1'b0, 5'b00000, 64'h0,
                    64'h8000_0000_FFFF_FF80, 1'b0, 1});

    // Reset during AMO READ: no write, reservation lost
    applyStimulus('{"lr pre rst", LR, 64'h40, 2'd3, 1'b0, 5'b00000, 64'h0, 64'h9, 1'b0, 1});
    req_valid = 1'b1; req_op = AMO; req_addr = 64'h80; req_size = 2'd2; req_amo = 5'b00000;
    req_wdata = 64'h5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst amo rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst amo req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus('{"rst amo ram", LOAD, 64'h80, 2'd3, 1'b0, 5'b00000, 64'h0,
                    64'h0000_0013_0000_0001, 1'b0, 1});
    applyStimulus('{"sc after rst", SC, 64'h40, 2'd3, 1'b0, 5'b00000, 64'h77, 64'h1, 1'b0, 1});
    applyStimulus('{"ld after rst", LOAD, 64'h40, 2'd3, 1'b0, 5'b00000, 64'h0, 64'h9, 1'b0, 1});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the load/store unit's data-memory request channel. Accepts one request at a time, tagged with a `mem_op_e` operation (LOAD, STORE, LR, SC, AMO), and executes it against an internal little-endian dword-organized RAM. Holds the single-hart LR/SC reservation and runs AMO read-modify-write sequences. Returns sign- or zero-extended load data and SC status on a valid/ready response channel. Serves as the data-memory model behind the core in simulation and FPGA builds.

## Interface

- `DEPTH`, 1024: RAM size in 64-bit dwords; power of two.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_op`  in  3  `mem_op_e` value: LOAD=001, STORE=010, LR=101, SC=110, AMO=111.
- `req_addr`  in  64  byte address.
- `req_size`  in  2  access size: 0=byte, 1=half, 2=word, 3=dword.
- `req_ext`  in  1  `size_ext_e` value: 0=SizeExtZero, 1=SizeExtSigned; used for LOAD only.
- `req_amo`  in  5  AMO funct5: ADD=00000, SWAP=00001, XOR=00100, OR=01000, AND=01100, MIN=10000, MAX=10100, MINU=11000, MAXU=11100.
- `req_wdata`  in  64  store/SC/AMO operand, right-aligned.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  64  load data, old AMO value, or SC status.
- `rsp_err`  out  1  access fault.

## Operation

- FSM states:
  - **IDLE**: `req_ready=1`. On `req_valid`, capture the request.
    - AMO with no fault: go to READ.
    - Any other request, or a faulting request: go to RESP.
  - **READ** (AMO only): latch the old value and compute the new value; go to WRITE.
  - **WRITE**: write the new value to RAM; go to RESP.
  - **RESP**: `rsp_valid=1` until `rsp_valid && rsp_ready`, then go to IDLE.
- Only one request is outstanding at a time. `req_ready=0` in every state except IDLE.
- Faults, checked at accept time:
  - misaligned address: `addr % (1<<size) != 0`;
  - `addr >= DEPTH*8`;
  - LR/SC/AMO with `req_size < 2`;
  - AMO with an unsupported funct5;
  - undefined `req_op`.
- A faulting request gives `rsp_err=1` and `rsp_rdata=0`. It writes nothing and does not change the reservation.
- LOAD: extract the selected bytes and extend to 64 bits per `req_ext`.
- STORE: byte-enabled write of the low `(1<<size)` bytes of `req_wdata`, performed at accept. If the store's dword index equals the reservation address, clear the reservation.
- LR: behave as a load, always sign-extended. Set `resv_valid=1` and `resv_addr = addr[63:3]`.
- SC: succeeds when `resv_valid` is set and the dword index matches.
  - Success: write, `rsp_rdata=0`.
  - Failure: no write, `rsp_rdata=1`.
  - Every non-faulting SC clears the reservation.
- AMO:
  - Word size operates on 32 bits; signed comparisons for MIN/MAX, unsigned for MINU/MAXU.
  - `rsp_rdata` = old value, sign-extended for word size.
  - A non-faulting AMO to the reserved dword clears the reservation.
- RAM contents are not reset. Out-of-range and faulting accesses never touch RAM.

## Timing

- Reset values: FSM=IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `resv_valid=0`.
- Latency, with accept at edge T:
  - LOAD/STORE/LR/SC/fault: `rsp_valid` high after T, i.e. the first response cycle is T+1.
  - AMO: `rsp_valid` first visible in cycle T+3 (READ, WRITE, then RESP).
- Back-to-back throughput: a new request can be accepted in the cycle after the response handshake.
- `rsp_rdata` and `rsp_err` stay stable while `rsp_valid=1 && rsp_ready=0`.
- The RAM write for STORE and SC happens at the accept edge. The AMO write happens at the WRITE edge.
- Reset asserted mid-operation:
  - immediate return to IDLE;
  - `rsp_valid` drops and the reservation clears;
  - an AMO reset before its WRITE edge leaves RAM unmodified.

## Test plan

- Store then load, sign extension:
  - STORE dword 0x8000_0000_FFFF_FF80 at 0x10.
  - LOAD byte at 0x10 with ext=1 -> rdata 0xFFFF_FFFF_FFFF_FF80.
  - LOAD byte at 0x10 with ext=0 -> rdata 0x80.
  - LOAD word at 0x14 with ext=1 -> 0xFFFF_FFFF_8000_0000.
- LR/SC:
  - LR dword 0x40, then SC at 0x40 with 0x5 -> rdata 0, and RAM holds 5.
  - Repeat the SC -> rdata 1, no write.
  - LR 0x40, STORE to 0x40, then SC -> rdata 1.
- AMO:
  - RAM[0x80] word = 0xFFFF_FFFE; AMO MIN.W with 1 -> rdata 0xFFFF_FFFF_FFFF_FFFE, RAM unchanged.
  - AMO MINU.W with 1 -> RAM becomes 1.
  - AMO ADD.D 0x7FFF_FFFF_FFFF_FFFF + 1 wraps to 0x8000_0000_0000_0000.
  - `rsp_valid` appears 3 cycles after accept.
- Faults:
  - LOAD half at 0x3 -> err=1, rdata=0.
  - LOAD at DEPTH*8 -> err=1.
  - LR byte -> err=1.
  - AMO funct5 00010 -> err=1 and RAM unchanged.
- Backpressure: hold `rsp_ready=0` for 5 cycles after a load -> `rsp_valid` and data stable, `req_ready=0`; the request accepted the cycle after the handshake.
- Reset mid-AMO: deassert `rst_n` in the READ cycle -> `rsp_valid=0`, `req_ready=1`, target RAM unchanged, a subsequent SC fails.
